ft_rx_deframer: RTL and testbench

//  Upstream stage of wishbone_master: consumes the FT245 sync RX byte stream (after clock crossing)
//  and reassembles it into host command frames. Frame = SYNC byte, 4B command, 4B address, N x 4B data,
//  all big-endian. Each data word is presented to wishbone_master as one ih_ready pulse with

---
 rtl/ft_host_pkg.sv | 9 +
 rtl/ft_rx_deframer_if.sv | 16 +
 rtl/ft_rx_word_shifter.sv | 26 ++
 rtl/ft_rx_deframer.sv | 77 +++++++
 tb/tb_ft_rx_deframer.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/ft_host_pkg.sv
// ft_host_pkg: FSM state encoding, sync marker and command field helpers shared by the host-side blocks
package ft_host_pkg;
  typedef enum logic [2:0] {FTRX_IDLE, FTRX_CMD, FTRX_ADDR, FTRX_DATA, FTRX_EMIT} ftrx_state_t;
  localparam logic [7:0] SYNC_BYTE_DEF = 8'hCD;
  localparam int CNT_W = 28;
  function automatic logic [CNT_W-1:0] words_m1(input logic [31:0] cmd);
    return (cmd[CNT_W-1:0] == '0) ? '0 : cmd[CNT_W-1:0] - CNT_W'(1);
  endfunction
endpackage

// File: rtl/ft_rx_deframer_if.sv
// ft_rx_deframer_if: RX byte stream in, reassembled command words out
//   rx_data/rx_valid/rx_ready : byte stream, accepted on rx_valid & rx_ready
//   master_ready/ih_ready     : word handshake toward wishbone_master
//   in_*, frame_err, sync_drop_count : frame fields and status
interface ft_rx_deframer_if;
  import ft_host_pkg::*;
  logic [7:0] rx_data;
  logic rx_valid, rx_ready, master_ready, ih_ready, frame_err;
  logic [31:0] in_command, in_address, in_data;
  logic [CNT_W-1:0] in_data_count;
  logic [15:0] sync_drop_count;
  modport slave(input rx_data, rx_valid, master_ready,
                output rx_ready, ih_ready, in_command, in_address, in_data, in_data_count, frame_err, sync_drop_count);
  modport master(output rx_data, rx_valid, master_ready,
                 input rx_ready, ih_ready, in_command, in_address, in_data, in_data_count, frame_err, sync_drop_count);
endinterface

// File: rtl/ft_rx_word_shifter.sv
// ft_rx_word_shifter: big-endian byte-to-word assembler
//   clr: drop partial word; en: shift din in; word: current word incl. din; done: en on 4th byte
module ft_rx_word_shifter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        done
);
  logic [1:0]  idx;
  logic [23:0] sh;
  assign word = {sh, din};
  assign done = en && idx == 2'd3;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx <= '0;
      sh  <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      sh  <= word[23:0];
      idx <= idx + 2'd1;
    end
endmodule

// File: rtl/ft_rx_deframer.sv
// ft_rx_deframer: reassembles SYNC/command/address/data frames from the RX byte stream
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of ft_rx_deframer_if (byte stream in, word strobe and status out)
module ft_rx_deframer
  import ft_host_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter int         TO_WIDTH       = 11
) (
  input logic            clk,
  input logic            rst_n,
  ft_rx_deframer_if.slave bus
);
  ftrx_state_t state, nxt;
  logic rdy, ferr, accept, in_frame, shift_en, timeout, emit, done;
  logic [31:0] cmd, addr, data, word;
  logic [CNT_W-1:0] rem;
  logic [TO_WIDTH-1:0] to_cnt;
  logic [15:0] drops;
  assign accept   = bus.rx_valid && rdy;
  assign in_frame = state inside {FTRX_CMD, FTRX_ADDR, FTRX_DATA};
  assign shift_en = accept && in_frame;
  assign timeout  = in_frame && !accept && to_cnt == TO_WIDTH'(TIMEOUT_CYCLES - 1);
  // strobe is combinational so the byte after it is accepted on the following cycle
  assign emit     = state == FTRX_EMIT && bus.master_ready;
  ft_rx_word_shifter u_shift (
    .clk(clk), .rst_n(rst_n), .clr(timeout), .en(shift_en),
    .din(bus.rx_data), .word(word), .done(done)
  );
  always_comb begin
    nxt = state;
    unique case (state)
      FTRX_IDLE: nxt = (accept && bus.rx_data == SYNC_BYTE) ? FTRX_CMD : FTRX_IDLE;
      FTRX_CMD:  nxt = timeout ? FTRX_IDLE : done ? FTRX_ADDR : FTRX_CMD;
      FTRX_ADDR: nxt = timeout ? FTRX_IDLE : done ? FTRX_DATA : FTRX_ADDR;
      FTRX_DATA: nxt = timeout ? FTRX_IDLE : done ? FTRX_EMIT : FTRX_DATA;
      FTRX_EMIT: nxt = !bus.master_ready ? FTRX_EMIT : (rem == '0) ? FTRX_IDLE : FTRX_DATA;
      default:   nxt = FTRX_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= FTRX_IDLE;
    else        state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rdy    <= 1'b0;
      ferr   <= 1'b0;
      to_cnt <= '0;
      drops  <= '0;
      cmd    <= '0;
      addr   <= '0;
      data   <= '0;
      rem    <= '0;
    end else begin
      rdy    <= nxt != FTRX_EMIT;
      ferr   <= timeout;
      to_cnt <= (in_frame && !accept && !timeout) ? to_cnt + TO_WIDTH'(1) : '0;
      if (state == FTRX_IDLE && accept && bus.rx_data != SYNC_BYTE && drops != 16'hFFFF)
        drops <= drops + 16'd1;
      if (done && state == FTRX_CMD) begin
        cmd <= word;
        rem <= words_m1(word);
      end
      if (done && state == FTRX_ADDR) addr <= word;
      if (done && state == FTRX_DATA) data <= word;
      if (emit && rem != '0) rem <= rem - CNT_W'(1);
    end
  assign bus.rx_ready        = rdy;
  assign bus.ih_ready        = emit;
  assign bus.frame_err       = ferr;
  assign bus.in_command      = cmd;
  assign bus.in_address      = addr;
  assign bus.in_data         = data;
  assign bus.in_data_count   = rem;
  assign bus.sync_drop_count = drops;
endmodule

// File: tb/tb_ft_rx_deframer.sv
// tb_ft_rx_deframer: directed self-checking bench for ft_rx_deframer
module tb_ft_rx_deframer;
  import ft_host_pkg::*;
  typedef struct {
    logic [31:0] c, a, d;
    logic [27:0] n;
  } strobe_t;
  logic clk = 1'b0, rst_n = 1'b0;
  int n_chk = 0, n_fail = 0, errs = 0;
  strobe_t q[$];
  strobe_t s;
  always #5 clk = ~clk;
  ft_rx_deframer_if bus();
  ft_rx_deframer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always @(negedge clk) begin
    if (bus.ih_ready) begin
      s.c = bus.in_command;
      s.a = bus.in_address;
      s.d = bus.in_data;
      s.n = bus.in_data_count;
      q.push_back(s);
    end
    if (bus.frame_err) errs++;
  end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] b);
    int w = 0;
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    while (!bus.rx_ready && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.rx_ready) chk("rx_ready_wait", 64'(bus.rx_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
  endtask
  task automatic send_word(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) send(w[8*i +: 8]);
  endtask
  task automatic send_frame(input logic [31:0] c, input logic [31:0] a, input logic [31:0] d0);
    send(8'hCD);
    send_word(c);
    send_word(a);
    send_word(d0);
  endtask
  task automatic chk_strobe(input string tag, input int i, input logic [31:0] c, input logic [31:0] a,
                            input logic [31:0] d, input logic [27:0] n);
    if (q.size() <= i) chk({tag, "_present"}, 64'(q.size()), 64'(i + 1));
    else begin
      chk({tag, "_cmd"}, 64'(q[i].c), 64'(c));
      chk({tag, "_addr"}, 64'(q[i].a), 64'(a));
      chk({tag, "_data"}, 64'(q[i].d), 64'(d));
      chk({tag, "_cnt"}, 64'(q[i].n), 64'(n));
    end
  endtask
  initial begin
    int bad, e0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    bus.master_ready = 1'b1;
    cyc(3);
    chk("rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("rst_ih_ready", 64'(bus.ih_ready), 64'd0);
    chk("rst_cmd", 64'(bus.in_command), 64'd0);
    chk("rst_drops", 64'(bus.sync_drop_count), 64'd0);
    chk("rst_ferr", 64'(bus.frame_err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_rx_ready0", 64'(bus.rx_ready), 64'd0);
    cyc(1);
    chk("release_rx_ready1", 64'(bus.rx_ready), 64'd1);
    q.delete();
    send_frame(32'h00000001, 32'h00000100, 32'hABCD1234);
    cyc(3);
    chk("single_n", 64'(q.size()), 64'd1);
    chk_strobe("single", 0, 32'h00000001, 32'h00000100, 32'hABCD1234, 28'd0);
    chk("single_idle", 64'(dut.state), 64'(FTRX_IDLE));
    q.delete();
    send_frame(32'h00000003, 32'h00000200, 32'h11111111);
    send_word(32'h22222222);
    send_word(32'h33333333);
    cyc(3);
    chk("burst_n", 64'(q.size()), 64'd3);
    chk_strobe("burst0", 0, 32'h00000003, 32'h00000200, 32'h11111111, 28'd2);
    chk_strobe("burst1", 1, 32'h00000003, 32'h00000200, 32'h22222222, 28'd1);
    chk_strobe("burst2", 2, 32'h00000003, 32'h00000200, 32'h33333333, 28'd0);
    q.delete();
    send_frame(32'h00000000, 32'h00000300, 32'h5555AAAA);
    cyc(3);
    chk("cnt0_n", 64'(q.size()), 64'd1);
    chk_strobe("cnt0", 0, 32'h00000000, 32'h00000300, 32'h5555AAAA, 28'd0);
    chk("cnt0_idle", 64'(dut.state), 64'(FTRX_IDLE));
    q.delete();
    bus.master_ready = 1'b0;
    send_frame(32'h00000002, 32'h00000400, 32'hAAAA5555);
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.rx_ready || bus.ih_ready) bad++;
    end
    chk("bp_stall", 64'(bad), 64'd0);
    chk("bp_no_strobe", 64'(q.size()), 64'd0);
    @(posedge clk);
    #1;
    bus.master_ready = 1'b1;
    @(negedge clk);
    chk("bp_strobe", 64'(bus.ih_ready), 64'd1);
    send_word(32'h5A5A0F0F);
    cyc(3);
    chk("bp_n", 64'(q.size()), 64'd2);
    chk_strobe("bp0", 0, 32'h00000002, 32'h00000400, 32'hAAAA5555, 28'd1);
    chk_strobe("bp1", 1, 32'h00000002, 32'h00000400, 32'h5A5A0F0F, 28'd0);
    q.delete();
    send(8'h00);
    send(8'hFF);
    send(8'h12);
    cyc(1);
    chk("garbage_drops", 64'(bus.sync_drop_count), 64'd3);
    send_frame(32'h00000001, 32'h000000CD, 32'hCDCDCDCD);
    cyc(3);
    chk("resync_n", 64'(q.size()), 64'd1);
    chk_strobe("resync", 0, 32'h00000001, 32'h000000CD, 32'hCDCDCDCD, 28'd0);
    chk("resync_drops", 64'(bus.sync_drop_count), 64'd3);
    q.delete();
    e0 = errs;
    send(8'hCD);
    send_word(32'h00000001);
    send(8'h00);
    cyc(1000);
    chk("to_early", 64'(errs - e0), 64'd0);
    cyc(40);
    chk("to_ferr", 64'(errs - e0), 64'd1);
    chk("to_no_strobe", 64'(q.size()), 64'd0);
    chk("to_idle", 64'(dut.state), 64'(FTRX_IDLE));
    send_frame(32'h00000001, 32'h00000500, 32'h12345678);
    cyc(3);
    chk("to_after_n", 64'(q.size()), 64'd1);
    chk_strobe("to_after", 0, 32'h00000001, 32'h00000500, 32'h12345678, 28'd0);
    chk("to_after_ferr", 64'(errs - e0), 64'd1);
    q.delete();
    send(8'hCD);
    send(8'h00);
    send(8'h00);
    bus.rx_data = 8'h11;
    bus.rx_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rx_ready", 64'(bus.rx_ready), 64'd0);
    chk("mid_rst_cmd", 64'(bus.in_command), 64'd0);
    chk("mid_rst_addr", 64'(bus.in_address), 64'd0);
    chk("mid_rst_data", 64'(bus.in_data), 64'd0);
    chk("mid_rst_drops", 64'(bus.sync_drop_count), 64'd0);
    chk("mid_rst_ih", 64'(bus.ih_ready), 64'd0);
    bus.rx_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_release0", 64'(bus.rx_ready), 64'd0);
    cyc(1);
    chk("mid_release1", 64'(bus.rx_ready), 64'd1);
    send_frame(32'h00000001, 32'h00000600, 32'h0BADF00D);
    cyc(3);
    chk("post_rst_n", 64'(q.size()), 64'd1);
    chk_strobe("post_rst", 0, 32'h00000001, 32'h00000600, 32'h0BADF00D, 28'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
